// File: rtl/bin_2_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// start/busy/done handshake with a sticky overflow for values >= 10^DIGITS.
module bin_2_bcd_seq #(
  parameter int unsigned BIN_WIDTH = 12,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_RAW = $clog2(BIN_WIDTH + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [CNT_W-1:0]     r_cnt;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]     r_scratch;
  logic                 r_sticky;
  logic                 r_busy;
  logic                 r_done;
  logic [BCD_W-1:0]     r_bcd;
  logic                 r_ovf;

  logic                 w_load;
  logic                 w_step;
  logic                 w_last;
  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_scratch_shl;
  logic [BIN_WIDTH-1:0] w_bin_shl;
  logic                 w_carry;
  logic                 w_cnt_is_one;

  assign w_cnt_is_one = (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)        w_state_next = S_SHIFT;
      S_SHIFT: if (w_cnt_is_one) w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE:  w_load = start;
      S_SHIFT: begin
        w_step = 1'b1;
        w_last = w_cnt_is_one;
      end
      default: ;
    endcase
  end

  // Add-3 correction, all digits judged on their pre-correction value
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_carry       = w_adj[BCD_W-1];
  assign w_scratch_shl = {w_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
  assign w_bin_shl     = r_bin << 1;

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bin     <= '0;
      r_scratch <= '0;
      r_sticky  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_bin     <= bin;
        r_scratch <= '0;
        r_sticky  <= 1'b0;
        r_cnt     <= CNT_W'(BIN_WIDTH);
        r_busy    <= 1'b1;
      end else if (w_step) begin
        r_bin     <= w_bin_shl;
        r_scratch <= w_scratch_shl;
        r_sticky  <= r_sticky | w_carry;
        r_cnt     <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_busy <= 1'b0;
          r_bcd  <= w_scratch_shl;
          r_ovf  <= r_sticky | w_carry;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_2_bcd_seq.sv
// Scoreboard bench for bin_2_bcd_seq: default instance plus DIGITS=3,
// 16-bit/5-digit and 1-bit/1-digit instances for overflow and width corners.
module tb_bin_2_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [11:0] bin;
  logic        busy, done, ovf;
  logic [15:0] bcd;

  logic        start3, busy3, done3, ovf3;
  logic [11:0] bin3;
  logic [11:0] bcd3;

  logic        start16, busy16, done16, ovf16;
  logic [15:0] bin16;
  logic [19:0] bcd16;

  logic        start1, busy1, done1, ovf1;
  logic [0:0]  bin1;
  logic [3:0]  bcd1;

  bin_2_bcd_seq #(.BIN_WIDTH(12), .DIGITS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(ovf));

  bin_2_bcd_seq #(.BIN_WIDTH(12), .DIGITS(3)) u_d3 (
    .clk(clk), .rst(rst), .start(start3), .bin(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3));

  bin_2_bcd_seq #(.BIN_WIDTH(16), .DIGITS(5)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16), .overflow(ovf16));

  bin_2_bcd_seq #(.BIN_WIDTH(1), .DIGITS(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd4(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Drive one request on the default instance and queue its expectation
  task automatic convert(input logic [11:0] v);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("idle_timeout", 32'(busy), 32'd0);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sb.push_back('{bcd: to_bcd4(int'(v)), ovf: (int'(v) >= 10000), acc: cyc});
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_done(output int t);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 50);
    check_eq("done_seen", 32'(done), 32'd1);
    t = cyc;
  endtask

  // Scoreboard monitor for the default instance
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("bcd", 32'(bcd), 32'(mon_e.bcd));
        check_eq("ovf", 32'(ovf), 32'(mon_e.ovf));
        check_eq("latency", 32'(cyc - mon_e.acc), 32'd12);
      end
      check_eq("done_and_busy", 32'(busy), 32'd0);
    end
  end

  task automatic run_aux(input int which, input logic [15:0] v, input logic [19:0] exp_bcd,
                         input logic exp_ovf, input int exp_lat);
    int t0;
    int guard;
    logic d;
    logic [19:0] b;
    logic o;
    @(negedge clk);
    case (which)
      0:       begin start3  = 1'b1; bin3  = 12'(v); end
      1:       begin start16 = 1'b1; bin16 = v;      end
      default: begin start1  = 1'b1; bin1  = 1'(v);  end
    endcase
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0; start16 = 1'b0; start1 = 1'b0;
    t0 = cyc;
    guard = 0;
    d = 1'b0; b = '0; o = 1'b0;
    while (guard < 40) begin
      case (which)
        0:       begin d = done3;  b = 20'(bcd3);  o = ovf3;  end
        1:       begin d = done16; b = bcd16;      o = ovf16; end
        default: begin d = done1;  b = 20'(bcd1);  o = ovf1;  end
      endcase
      if (d) break;
      @(negedge clk);
      guard++;
    end
    check_eq($sformatf("aux%0d_done", which), 32'(d), 32'd1);
    check_eq($sformatf("aux%0d_lat", which), 32'(cyc - t0), 32'(exp_lat));
    check_eq($sformatf("aux%0d_bcd_%0d", which, v), 32'(b), 32'(exp_bcd));
    check_eq($sformatf("aux%0d_ovf_%0d", which, v), 32'(o), 32'(exp_ovf));
  endtask

  initial begin
    int t1, t2;
    rst = 1'b1; start = 1'b0; bin = '0;
    start3 = 1'b0; bin3 = '0; start16 = 1'b0; bin16 = '0; start1 = 1'b0; bin1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_bcd", 32'(bcd), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    convert(12'd0);
    wait_drain();

    for (int v = 0; v < 4096; v++) convert(12'(v));
    wait_drain();
    check_eq("sweep_last", 32'(bcd), 32'h4095);

    // Starts while busy are ignored; a start in the done cycle is accepted
    convert(12'd42);
    @(negedge clk);
    start = 1'b1;
    bin   = 12'd77;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done(t1);
    check_eq("hs_first", 32'(bcd), 32'h0042);
    start = 1'b1;
    bin   = 12'd77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sb.push_back('{bcd: 16'h0077, ovf: 1'b0, acc: cyc});
    wait_done(t2);
    check_eq("hs_spacing", 32'(t2 - t1), 32'd13);
    check_eq("hs_second", 32'(bcd), 32'h0077);
    wait_drain();

    // Reset mid-conversion aborts without a done
    convert(12'd4095);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_bcd", 32'(bcd), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    sb.delete();
    rst = 1'b0;
    repeat (15) @(negedge clk);
    convert(12'd7);
    wait_drain();
    check_eq("after_abort", 32'(bcd), 32'h0007);

    run_aux(0, 16'd999,  20'h999, 1'b0, 12);
    run_aux(0, 16'd1000, 20'h000, 1'b1, 12);
    run_aux(0, 16'd1234, 20'h234, 1'b1, 12);
    run_aux(0, 16'd4095, 20'h095, 1'b1, 12);
    run_aux(0, 16'd7,    20'h007, 1'b0, 12);
    run_aux(1, 16'd65535, 20'h65535, 1'b0, 16);
    run_aux(1, 16'd10000, 20'h10000, 1'b0, 16);
    run_aux(2, 16'd1, 20'h1, 1'b0, 1);
    run_aux(2, 16'd0, 20'h0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
